// File: rtl/status_register.sv
// Condition-flag status register between EX and the condition-check stage.
// Purpose: stores {Z,C,N,V} on a committed S-bit update, flags value changes
// and counts committed updates with a saturating counter.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   flush      discards this cycle's EX flag update
//   freeze     pipeline stall, holds all state
//   s_en       S bit of the EX instruction, requests an update
//   flags_in   ALU flags {Z,C,N,V} (bit3=Z, bit2=C, bit1=N, bit0=V)
//   status_out flags delivered to the condition-check stage
//   changed    one-cycle pulse after a commit that altered the stored flags
//   upd_count  saturating count of committed updates
// Build option: define STATUS_FWD_EN to forward flags_in to status_out
// in the commit cycle (zero-cycle write-to-read latency).
module status_register #(
    parameter int STATUS_LEN = 4,
    parameter int CNT_LEN    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  freeze,
    input  logic                  s_en,
    input  logic [STATUS_LEN-1:0] flags_in,
    output logic [STATUS_LEN-1:0] status_out,
    output logic                  changed,
    output logic [CNT_LEN-1:0]    upd_count
);

    localparam logic [CNT_LEN-1:0] CNT_ONE = {{(CNT_LEN-1){1'b0}}, 1'b1};
    localparam logic [CNT_LEN-1:0] CNT_MAX = {CNT_LEN{1'b1}};

    logic [STATUS_LEN-1:0] status_q;
    logic                  changed_q;
    logic [CNT_LEN-1:0]    cnt_q;
    logic                  commit;

    // Reset, flush and freeze all veto the update; rst is already
    // folded in here so the forwarding mux can reuse this term.
    assign commit = s_en & ~flush & ~freeze & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            status_q  <= '0;
            changed_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            // changed is a pulse, so it drops even while frozen
            changed_q <= commit && (flags_in != status_q);
            if (commit) begin
                status_q <= flags_in;
                if (cnt_q != CNT_MAX) begin
                    cnt_q <= cnt_q + CNT_ONE;
                end
            end
        end
    end

`ifdef STATUS_FWD_EN
    assign status_out = commit ? flags_in : status_q;
`else
    assign status_out = status_q;
`endif

    assign changed   = changed_q;
    assign upd_count = cnt_q;

endmodule

// File: tb/tb_status_register.sv
// Bench for status_register: directed vectors, expected results queued at
// stimulus time and compared by an independent per-cycle monitor.
module tb_status_register;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        freeze;
    logic        s_en;
    logic [3:0]  flags_in;
    logic [3:0]  status_out;
    logic        changed;
    logic [15:0] upd_count;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [3:0]  status;
        logic        chg;
        logic [15:0] cnt;
        string       name;
    } exp_t;

    exp_t exp_q[$];

    logic [3:0] prev_status = 4'h0;
    bit         known       = 0;

    status_register #(
        .STATUS_LEN(4),
        .CNT_LEN(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .flush(flush),
        .freeze(freeze),
        .s_en(s_en),
        .flags_in(flags_in),
        .status_out(status_out),
        .changed(changed),
        .upd_count(upd_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every queued expectation belongs to the edge just taken.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if (status_out === e.status && changed === e.chg
                    && upd_count === e.cnt) begin
                    passed++;
                end else begin
                    $display("FAIL %s: got status=%h changed=%b cnt=%h, want status=%h changed=%b cnt=%h",
                             e.name, status_out, changed, upd_count,
                             e.status, e.chg, e.cnt);
                end
            end
        end
    end

    // Drive one cycle at the falling edge and queue its post-edge result.
    task automatic step(input logic r, input logic fl, input logic fz,
                        input logic s, input logic [3:0] f,
                        input logic [3:0] es, input logic ec,
                        input logic [15:0] en, input string name);
        logic [3:0] pre;
        exp_t e;
        @(negedge clk);
        rst = r; flush = fl; freeze = fz; s_en = s; flags_in = f;
        #1;
        if (known) begin
            pre = prev_status;
`ifdef STATUS_FWD_EN
            if (s && !fl && !fz && !r) pre = f;
`endif
            total++;
            if (status_out === pre) passed++;
            else $display("FAIL %s_pre: got status=%h, want %h",
                          name, status_out, pre);
        end
        e.status = es; e.chg = ec; e.cnt = en; e.name = name;
        exp_q.push_back(e);
        prev_status = es;
        known = 1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; freeze = 1'b0; s_en = 1'b0;
        flags_in = 4'h0;

        step(1, 0, 0, 1, 4'hF, 4'h0, 0, 16'd0, "reset_a");
        step(1, 0, 0, 1, 4'hF, 4'h0, 0, 16'd0, "reset_b");
        step(0, 0, 0, 1, 4'h8, 4'h8, 1, 16'd1, "first_commit");
        step(0, 0, 0, 0, 4'h3, 4'h8, 0, 16'd1, "idle_hold");
        step(0, 1, 0, 1, 4'h6, 4'h8, 0, 16'd1, "flush_blocks");
        step(0, 0, 1, 1, 4'h6, 4'h8, 0, 16'd1, "freeze_blocks");
        step(0, 1, 1, 1, 4'h6, 4'h8, 0, 16'd1, "flush_freeze");
        step(0, 0, 0, 1, 4'h2, 4'h2, 1, 16'd2, "b2b_same_1");
        step(0, 0, 0, 1, 4'h2, 4'h2, 0, 16'd3, "b2b_same_2");
        step(0, 0, 0, 0, 4'h2, 4'h2, 0, 16'd3, "idle_after");
        step(0, 0, 0, 1, 4'h5, 4'h5, 1, 16'd4, "b2b_diff_1");
        step(0, 0, 0, 1, 4'h9, 4'h9, 1, 16'd5, "b2b_diff_2");
        step(0, 0, 1, 1, 4'h3, 4'h9, 0, 16'd5, "freeze_drops_chg");
        step(0, 0, 0, 1, 4'h1, 4'h1, 1, 16'd6, "pre_rst_commit");
        step(1, 0, 0, 1, 4'hF, 4'h0, 0, 16'd0, "midstream_rst");
        step(0, 0, 0, 1, 4'hF, 4'hF, 1, 16'd1, "post_rst_commit");
        step(0, 0, 0, 0, 4'h0, 4'hF, 0, 16'd1, "post_rst_idle");

        step(1, 0, 0, 0, 4'h0, 4'h0, 0, 16'd0, "sat_reset");
        for (int i = 1; i <= 65534; i++) begin
            step(0, 0, 0, 1, 4'h0, 4'h0, 0, 16'(i), "sat_preload");
        end
        step(0, 0, 0, 1, 4'h4, 4'h4, 1, 16'hFFFF, "sat_reach");
        step(0, 0, 0, 1, 4'h4, 4'h4, 0, 16'hFFFF, "sat_hold_1");
        step(0, 0, 0, 1, 4'h0, 4'h0, 1, 16'hFFFF, "sat_hold_2");
        step(0, 0, 0, 0, 4'h0, 4'h0, 0, 16'hFFFF, "sat_idle");

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clk);
            #2;
        end
        if (exp_q.size() > 0) begin
            total++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
